// File: rtl/axi_rd_burst_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_rd_burst_sched                                               |
// | Purpose  : Splits a linear read command into 4 KB-safe AXI4 INCR bursts.    |
// |            Keeps several bursts in flight and captures the first R error.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_rd_burst_sched #(
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 64,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ARUSER_WIDTH = 1,
  parameter int C_M_AXI_RUSER_WIDTH  = 1,
  parameter int MAX_BURST            = 256,
  parameter int MAX_OUTST            = 4,
  parameter int BEAT_W               = 20
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [BEAT_W-1:0]               cmd_beats,
  output logic                            done,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]  M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic                            rd_last,
  output logic                            rerror,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   rerror_addr
);

  localparam int c_BPB  = C_M_AXI_DATA_WIDTH / 8;
  localparam int c_SIZE = $clog2(c_BPB);
  localparam int c_PW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int c_OW   = $clog2(MAX_OUTST + 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_AMASK = C_M_AXI_ADDR_WIDTH'(c_BPB - 1);
  localparam logic [BEAT_W:0]               c_MAXB  = (BEAT_W+1)'(MAX_BURST);
  localparam logic [c_OW-1:0]               c_OMAX  = c_OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_cur_addr;
  logic [BEAT_W-1:0]               r_rem_ar;
  logic [BEAT_W-1:0]               r_rem_r;
  logic [c_OW-1:0]                 r_outst;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_fifo [MAX_OUTST];
  logic [c_PW-1:0]                 r_wr_ptr;
  logic [c_PW-1:0]                 r_rd_ptr;
  logic                            r_rerror;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_rerror_addr;

  logic                            w_accept;
  logic                            w_arvalid;
  logic                            w_ar_hs;
  logic                            w_r_hs;
  logic                            w_pop;
  logic [12:0]                     w_page_beats;
  logic [BEAT_W:0]                 w_page_ext;
  logic [BEAT_W:0]                 w_len;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_step;
  logic                            w_unused_ok;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(MAX_OUTST - 1)) ? '0 : p + c_PW'(1);
  endfunction

  // Beats left before the next 4 KB page, then clipped to remaining work and MAX_BURST.
  assign w_page_beats = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> c_SIZE;
  assign w_page_ext   = (BEAT_W+1)'(w_page_beats);

  always_comb begin
    w_len = {1'b0, r_rem_ar};
    if (w_page_ext < w_len) w_len = w_page_ext;
    if (c_MAXB < w_len)     w_len = c_MAXB;
  end

  assign w_step    = C_M_AXI_ADDR_WIDTH'(w_len) << c_SIZE;
  assign w_accept  = cmd_valid && cmd_ready;
  // cur_addr/rem_ar only move on a handshake and outstanding only drops, so
  // once raised ARVALID/ARADDR/ARLEN stay put until ARREADY.
  assign w_arvalid = (r_state == S_ADDR) && (r_outst < c_OMAX);
  assign w_ar_hs   = w_arvalid && M_AXI_ARREADY;
  assign w_r_hs    = M_AXI_RVALID && rd_ready;
  assign w_pop     = w_r_hs && M_AXI_RLAST && (r_outst != '0);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_cur_addr;
  assign M_AXI_ARLEN   = 8'(w_len - (BEAT_W+1)'(1));
  assign M_AXI_ARSIZE  = 3'(c_SIZE);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = w_arvalid;

  assign M_AXI_RREADY = rd_ready;
  assign rd_data      = M_AXI_RDATA;
  assign rd_valid     = M_AXI_RVALID;
  assign rd_last      = M_AXI_RVALID && (r_rem_r == BEAT_W'(1));
  assign rerror       = r_rerror;
  assign rerror_addr  = r_rerror_addr;
  assign w_unused_ok  = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0]};

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = (cmd_beats == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        if (w_ar_hs && ({1'b0, r_rem_ar} == w_len)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_rem_r == '0) && (r_outst == '0)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= S_IDLE;
      r_cur_addr    <= '0;
      r_rem_ar      <= '0;
      r_rem_r       <= '0;
      r_outst       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rerror      <= 1'b0;
      r_rerror_addr <= '0;
      for (int i = 0; i < MAX_OUTST; i++) r_fifo[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cur_addr    <= cmd_addr & ~c_AMASK;
        r_rem_ar      <= cmd_beats;
        r_rem_r       <= cmd_beats;
        r_rerror      <= 1'b0;
        r_rerror_addr <= '0;
      end else begin
        if (w_ar_hs) begin
          r_cur_addr <= r_cur_addr + w_step;
          r_rem_ar   <= r_rem_ar - w_len[BEAT_W-1:0];
        end
        if (w_r_hs && (r_rem_r != '0)) r_rem_r <= r_rem_r - BEAT_W'(1);
        // FIFO head is the start address of the burst currently returning data.
        if (w_r_hs && M_AXI_RRESP[1] && !r_rerror) begin
          r_rerror      <= 1'b1;
          r_rerror_addr <= r_fifo[r_rd_ptr];
        end
      end
      if (w_ar_hs) begin
        r_fifo[r_wr_ptr] <= r_cur_addr;
        r_wr_ptr         <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_ar_hs && !w_pop)      r_outst <= r_outst + c_OW'(1);
      else if (!w_ar_hs && w_pop) r_outst <= r_outst - c_OW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_burst_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_rd_burst_sched                                            |
// | Purpose  : Randomized AXI slave plus burst-list reference for the scheduler.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_rd_burst_sched;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, done;
  logic [AW-1:0] cmd_addr;
  logic [19:0]   cmd_beats;
  logic [0:0]    arid, aruser, rid, ruser;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, rresp;
  logic          arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]    arcache, arqos;
  logic [DW-1:0] rdata, rd_data;
  logic          rd_valid, rd_ready, rd_last, rerror;
  logic [AW-1:0] rerror_addr;

  axi_rd_burst_sched dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_beats(cmd_beats), .done(done),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .rerror(rerror), .rerror_addr(rerror_addr)
  );

  burst_t        expq[$];
  burst_t        sq[$];
  burst_t        obs[$];
  int            total = 0, bad = 0;
  int            n_ar = 0, n_last = 0, done_cnt = 0;
  bit            m_idle = 1'b1, m_err = 1'b0;
  logic [AW-1:0] m_err_addr = '0;
  int            m_rem = 0, m_outst = 0;
  bit            c_pend = 1'b0;
  logic [AW-1:0] c_addr = '0;
  int            c_beats = 0;
  int            ar_mode = 0;
  bit            rv_en = 1'b1, rr_all = 1'b0, rv_hold = 1'b0;
  int            s_beat = 0, s_bidx = 0;
  int            err_b1 = -1, err_k1 = -1, err_b2 = -1;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Expected burst list straight from the splitting rules.
  task automatic build_exp(input logic [AW-1:0] addr, input int beats);
    burst_t b;
    longint a   = longint'(addr) & ~longint'(7);
    int     rem = beats;
    int     n, page;
    while (rem > 0) begin
      page = (4096 - int'(a % 4096)) / 8;
      n = rem;
      if (page < n) n = page;
      if (256 < n)  n = 256;
      b.addr = AW'(a);
      b.len  = 8'(n - 1);
      expq.push_back(b);
      a   += longint'(n) * 8;
      rem -= n;
    end
  endtask

  function automatic logic [1:0] resp_for();
    if (s_bidx == err_b1 && s_beat == err_k1) return 2'b10;
    if (s_bidx == err_b2) return 2'b11;
    return 2'b00;
  endfunction

  task automatic tick();
    bit     arhs, rhs, acc;
    burst_t b;
    @(negedge clk);
    cmd_valid = c_pend;
    cmd_addr  = c_addr;
    cmd_beats = 20'(c_beats);
    case (ar_mode)
      1:       arready = 1'b1;
      2:       arready = 1'b0;
      default: arready = ($urandom_range(0, 3) != 0);
    endcase
    if (!rv_hold) begin
      if (rv_en && sq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rvalid = 1'b1;
        rdata  = {$urandom(), $urandom()};
        rlast  = (s_beat == int'(sq[0].len));
        rresp  = resp_for();
        rid    = 1'($urandom());
        ruser  = 1'($urandom());
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
    rd_ready = rr_all ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    chk("cmd_ready", cmd_ready, m_idle);
    chk("arvalid", arvalid, (expq.size() > 0) && (m_outst < MAXO));
    if (arvalid && expq.size() > 0) begin
      chk("araddr", araddr, expq[0].addr);
      chk("arlen", arlen, expq[0].len);
    end
    chk("rready", rready, rd_ready);
    if (rvalid) begin
      chk("rd_data", rd_data, rdata);
      chk("rd_valid", rd_valid, 1'b1);
    end
    chk("rd_last", rd_last, rvalid && (m_rem == 1));
    chk("rerror", rerror, m_err);
    chk("rerror_addr", rerror_addr, m_err_addr);
    if (done)
      chk("done_ok", {m_idle, m_rem == 0, expq.size() == 0, m_outst == 0}, 4'b0111);
    arhs = arvalid && arready;
    rhs  = rvalid && rready;
    acc  = cmd_valid && cmd_ready;
    if (arhs)
      chk("ar_const", {arid, arsize, arburst, arlock, arcache, arprot, arqos, aruser},
          {1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
    if (rhs && sq.size() > 0) begin
      if (rd_last) n_last++;
      if (rresp[1] && !m_err) begin
        m_err      = 1'b1;
        m_err_addr = sq[0].addr;
      end
      m_rem--;
      if (rlast) begin
        void'(sq.pop_front());
        m_outst--;
        s_beat = 0;
        s_bidx++;
      end else begin
        s_beat++;
      end
    end
    rv_hold = rvalid && !rhs;
    if (arhs) begin
      b.addr = araddr;
      b.len  = arlen;
      sq.push_back(b);
      obs.push_back(b);
      if (expq.size() > 0) void'(expq.pop_front());
      m_outst++;
      n_ar++;
    end
    if (done) begin
      m_idle = 1'b1;
      done_cnt++;
    end
    if (acc) begin
      c_pend     = 1'b0;
      m_idle     = 1'b0;
      m_err      = 1'b0;
      m_err_addr = '0;
      m_rem      = c_beats;
      n_last     = 0;
      s_bidx     = 0;
      s_beat     = 0;
      obs.delete();
      build_exp(c_addr, c_beats);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
    expq.delete(); sq.delete(); obs.delete();
    m_idle = 1'b1; m_err = 1'b0; m_err_addr = '0; m_rem = 0; m_outst = 0;
    rv_hold = 1'b0; c_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rerror", {rerror, rerror_addr}, '0);
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input int beats);
    c_addr  = a;
    c_beats = beats;
    c_pend  = 1'b1;
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk("done_seen", done_cnt != d0, 1'b1);
    if (c_beats > 0) chk("rd_last_cnt", n_last, 1);
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input int beats);
    int d0 = done_cnt;
    start_cmd(a, beats);
    wait_done(20000, d0);
  endtask

  initial begin
    int d0, ar0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    rid = '0; ruser = '0; rd_ready = 1'b0;
    do_reset();

    run_cmd(32'h0000_1000, 600);
    chk("t1_nbursts", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t1_b0", obs[0], {32'h1000, 8'd255});
      chk("t1_b1", obs[1], {32'h1800, 8'd255});
      chk("t1_b2", obs[2], {32'h2000, 8'd87});
    end

    run_cmd(32'h0000_0FF8, 4);
    chk("t2_nbursts", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("t2_b0", obs[0], {32'h0FF8, 8'd0});
      chk("t2_b1", obs[1], {32'h1000, 8'd2});
    end

    ar0 = n_ar;
    run_cmd(32'h0000_0400, 0);
    chk("t3_no_ar", n_ar - ar0, 0);

    err_b1 = 1; err_k1 = 2; err_b2 = 2;
    run_cmd(32'h0000_2000, 600);
    chk("t5_rerror", rerror, 1'b1);
    chk("t5_rerror_addr", rerror_addr, 32'h0000_2800);
    err_b1 = -1; err_k1 = -1; err_b2 = -1;

    ar_mode = 2;
    start_cmd(32'h0000_0000, 2048);
    repeat (3) tick();
    chk("t6_pre_arvalid", arvalid, 1'b1);
    chk("t6_err_cleared", rerror, 1'b0);
    do_reset();

    ar_mode = 1; rv_en = 1'b0;
    d0 = done_cnt; ar0 = n_ar;
    start_cmd(32'h0000_0000, 2048);
    repeat (20) tick();
    chk("t4_outst_limit", n_ar - ar0, MAXO);
    rv_en = 1'b1;
    wait_done(20000, d0);
    chk("t4_nbursts", obs.size(), 8);

    for (int k = 0; k < 6; k++) begin
      ar_mode = int'($urandom_range(0, 1));
      rr_all  = 1'($urandom_range(0, 1));
      run_cmd(AW'($urandom_range(0, 32'h0003_FFFF)),
              (k == 2) ? 0 : int'($urandom_range(1, 700)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
